// File: rtl/pipe_pkg.sv
// Shared types and helpers for the RV32I pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_HALTED
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             reg_wr;
    logic             mem_rd;
    logic             valid;
  } stage_info_t;

  // A producer matches a consumer only if it writes a register other than x0
  function automatic logic rd_hit(input logic wr, input logic [REG_W-1:0] rd,
                                  input logic [REG_W-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority forwarding select for one E-stage operand: M result beats W result.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] m_rd_i,
  input  logic             m_wr_i,
  input  logic             m_ld_i,
  input  logic [REG_W-1:0] w_rd_i,
  input  logic             w_wr_i,
  output fwd_sel_e         sel_o
);

  // Loads in M have no data yet; the load-use stall moves them to W first
  always_comb begin
    sel_o = FWD_REG;
    if (rd_hit(m_wr_i && !m_ld_i, m_rd_i, rs_i)) begin
      sel_o = FWD_M;
    end else if (rd_hit(w_wr_i, w_rd_i, rs_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline.
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining HAZ_PERF_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned INIT_FLUSH = 4
`ifdef HAZ_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_addr_D,
  input  logic [REG_W-1:0] rs2_addr_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic [REG_W-1:0] rd_D,
  input  logic             reg_wr_D,
  input  logic             mem_rd_D,
  input  logic             br_en_E,
  input  logic             halt_req,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             byp_rs1_D,
  output logic             byp_rs2_D,
  output logic             halted
`ifdef HAZ_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned INIT_W = (INIT_FLUSH > 1) ? $clog2(INIT_FLUSH) : 1;

  hz_state_e   state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  stage_info_t e_q, m_q, w_q;
  stage_info_t d_info_c;
  logic        load_use_c;
  logic        busy_c;
  fwd_sel_e    fwd_a_c, fwd_b_c;
  logic        unused_shadow;

  assign d_info_c = '{rd: rd_D, rs1: rs1_addr_D, rs2: rs2_addr_D,
                      reg_wr: reg_wr_D, mem_rd: mem_rd_D, valid: 1'b1};

  assign load_use_c = e_q.mem_rd && (e_q.rd != '0) &&
                      ((use_rs1_D && (rs1_addr_D == e_q.rd)) ||
                       (use_rs2_D && (rs2_addr_D == e_q.rd)));

  assign busy_c = (e_q.valid && (e_q.reg_wr || e_q.mem_rd)) ||
                  (m_q.valid && (m_q.reg_wr || m_q.mem_rd)) ||
                  (w_q.valid && (w_q.reg_wr || w_q.mem_rd));

  // Source operands of M/W are carried along but only E needs them
  assign unused_shadow = ^{m_q.rs1, m_q.rs2, w_q.rs1, w_q.rs2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      e_q        <= '0;
      m_q        <= '0;
      w_q        <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      e_q        <= flush_E ? stage_info_t'('0) : d_info_c;
      m_q        <= e_q;
      w_q        <= m_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_INIT: begin
        stall_F = 1'b1;
        flush_D = 1'b1;
        flush_E = 1'b1;
        if (init_cnt_q == INIT_W'(INIT_FLUSH - 1)) begin
          state_d = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      S_RUN: begin
        if (load_use_c) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end
        if (halt_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
        if (!busy_c) state_d = S_HALTED;
      end
      S_HALTED: begin
        halted  = 1'b1;
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
        if (!halt_req) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
    // A taken branch squashes D and E; in RUN it also releases a load-use stall
    if ((state_q != S_INIT) && br_en_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      if (state_q == S_RUN) begin
        stall_F = 1'b0;
        stall_D = 1'b0;
      end
    end
  end

  fwd_sel u_fwd_a (
    .rs_i   (e_q.rs1),
    .m_rd_i (m_q.rd),
    .m_wr_i (m_q.reg_wr),
    .m_ld_i (m_q.mem_rd),
    .w_rd_i (w_q.rd),
    .w_wr_i (w_q.reg_wr),
    .sel_o  (fwd_a_c)
  );

  fwd_sel u_fwd_b (
    .rs_i   (e_q.rs2),
    .m_rd_i (m_q.rd),
    .m_wr_i (m_q.reg_wr),
    .m_ld_i (m_q.mem_rd),
    .w_rd_i (w_q.rd),
    .w_wr_i (w_q.reg_wr),
    .sel_o  (fwd_b_c)
  );

  assign fwd_a_E   = fwd_a_c;
  assign fwd_b_E   = fwd_b_c;
  assign byp_rs1_D = use_rs1_D && rd_hit(w_q.reg_wr, w_q.rd, rs1_addr_D);
  assign byp_rs2_D = use_rs2_D && rd_hit(w_q.reg_wr, w_q.rd, rs2_addr_D);

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu_cnt_c, br_cnt_c;

  assign lu_cnt_c = (state_q == S_RUN) && load_use_c && !br_en_E;
  assign br_cnt_c = (state_q != S_INIT) && br_en_E;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_cnt_c && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_cnt_c && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: sequential vector table plus reset corner cases.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    logic       halt;
  } vin_t;

  typedef struct packed {
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       b1;
    logic       b2;
    logic       hl;
  } vout_t;

  typedef struct {
    string name;
    vin_t  vi;
    vout_t vo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_addr_D, rs2_addr_D, rd_D;
  logic       use_rs1_D, use_rs2_D, reg_wr_D, mem_rd_D, br_en_E, halt_req;
  logic       stall_F, stall_D, flush_D, flush_E, byp_rs1_D, byp_rs2_D, halted;
  logic [1:0] fwd_a_E, fwd_b_E;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  vec_t  vecs[$];
  vout_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_D (rs1_addr_D),
    .rs2_addr_D (rs2_addr_D),
    .use_rs1_D  (use_rs1_D),
    .use_rs2_D  (use_rs2_D),
    .rd_D       (rd_D),
    .reg_wr_D   (reg_wr_D),
    .mem_rd_D   (mem_rd_D),
    .br_en_E    (br_en_E),
    .halt_req   (halt_req),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .flush_D    (flush_D),
    .flush_E    (flush_E),
    .fwd_a_E    (fwd_a_E),
    .fwd_b_E    (fwd_b_E),
    .byp_rs1_D  (byp_rs1_D),
    .byp_rs2_D  (byp_rs2_D),
    .halted     (halted)
`ifdef HAZ_PERF_EN
    , .stall_cnt (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  function automatic vin_t mk_in(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic wr, input logic ld, input logic br,
                                 input logic halt);
    vin_t v;
    v = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, wr: wr, ld: ld, br: br, halt: halt};
    return v;
  endfunction

  function automatic vout_t mk_out(input logic sf, input logic sd, input logic fd,
                                   input logic fe, input logic [1:0] fa, input logic [1:0] fb,
                                   input logic b1, input logic b2, input logic hl);
    vout_t v;
    v = '{sf: sf, sd: sd, fd: fd, fe: fe, fa: fa, fb: fb, b1: b1, b2: b2, hl: hl};
    return v;
  endfunction

  function automatic vout_t cur_out();
    return mk_out(stall_F, stall_D, flush_D, flush_E, fwd_a_E, fwd_b_E,
                  byp_rs1_D, byp_rs2_D, halted);
  endfunction

  task automatic drive(input vin_t v);
    rs1_addr_D = v.rs1;
    rs2_addr_D = v.rs2;
    use_rs1_D  = v.u1;
    use_rs2_D  = v.u2;
    rd_D       = v.rd;
    reg_wr_D   = v.wr;
    mem_rd_D   = v.ld;
    br_en_E    = v.br;
    halt_req   = v.halt;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, expv);
    end
  endtask

  task automatic add(input string n, input vin_t vi, input vout_t vo);
    vec_t v;
    v.name = n;
    v.vi   = vi;
    v.vo   = vo;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vout_t o0, o_init, o_lu, o_br, o_dr, o_hl, e;
    vin_t  nop, hreq;
    string nm;

    o0     = mk_out(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    o_init = mk_out(1, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    o_lu   = mk_out(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    o_br   = mk_out(0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    o_dr   = mk_out(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    o_hl   = mk_out(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 1);
    nop    = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    hreq   = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // start-up bubbles
    for (int i = 0; i < 4; i++) add($sformatf("init%0d", i), nop, o_init);
    add("run0",     nop, o0);
    // load-use: lw x5 then add x6,x5,x7
    add("lu_ld",    mk_in(1, 0, 1, 0, 5, 1, 1, 0, 0), o0);
    add("lu_stall", mk_in(5, 7, 1, 1, 6, 1, 0, 0, 0), o_lu);
    add("lu_hold",  mk_in(5, 7, 1, 1, 6, 1, 0, 0, 0), o0);
    add("lu_fwdw",  nop, mk_out(0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    // M beats W for x3, then x0 never forwards
    add("m3a",      mk_in(1, 0, 1, 0, 3, 1, 0, 0, 0), o0);
    add("m3b",      mk_in(2, 0, 1, 0, 3, 1, 0, 0, 0), o0);
    add("m3c",      mk_in(3, 3, 1, 1, 4, 1, 0, 0, 0), o0);
    add("m3fwd",    mk_in(0, 0, 1, 0, 0, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0));
    add("x0a",      mk_in(0, 0, 1, 0, 0, 1, 0, 0, 0), o0);
    add("x0b",      nop, o0);
    add("x0c",      mk_in(0, 0, 1, 1, 5, 1, 0, 0, 0), o0);
    // branch during load-use
    add("br_ld",    mk_in(2, 0, 1, 0, 8, 1, 1, 0, 0), o0);
    add("br_lu",    mk_in(8, 1, 1, 1, 9, 1, 0, 1, 0), o_br);
    add("br_after", nop, o0);
    add("byp_ld",   mk_in(0, 8, 1, 1, 1, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0));
    // W-stage bypass and W forwarding on operand b
    add("g1",       mk_in(0, 0, 1, 0, 9, 1, 0, 0, 0), o0);
    add("g2",       nop, o0);
    add("g3_byp1",  mk_in(1, 9, 1, 1, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0));
    add("g4_byp2",  mk_in(0, 9, 1, 1, 2, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 2'b00, 2'b01, 0, 1, 0));
    add("g5",       nop, o0);
    // halt with three writers in flight
    add("h1",       mk_in(0, 0, 1, 0, 10, 1, 0, 0, 0), o0);
    add("h2",       mk_in(0, 0, 1, 0, 11, 1, 0, 0, 0), o0);
    add("h3",       mk_in(0, 0, 1, 0, 12, 1, 0, 0, 0), o0);
    add("h_req",    hreq, o0);
    add("dr1",      hreq, o_dr);
    add("dr2",      hreq, o_dr);
    add("dr3",      hreq, o_dr);
    add("hl1",      hreq, o_hl);
    add("hl2",      nop, o_hl);
    add("run1",     nop, o0);
    // halt and branch together
    add("hb",       mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1), o_br);
    add("hb_dr",    hreq, o_dr);
    add("hb_hl",    nop, o_hl);
    add("j2",       mk_in(0, 0, 1, 0, 13, 1, 0, 0, 0), o0);
    add("j3",       hreq, o0);
    add("j4",       hreq, o_dr);

    drive(nop);
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_low%0d", i), 32'(cur_out()), 32'(o_init));
    end
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].vi);
      exp_q.push_back(vecs[k].vo);
      name_q.push_back(vecs[k].name);
      #1;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, 32'(cur_out()), 32'(e));
      @(negedge clk);
    end

    // still draining (x13 in W), D reads x13 -> bypass, then async reset
    drive(mk_in(13, 0, 1, 0, 0, 0, 0, 0, 1));
    #1 chk("pre_rst_drain", 32'(cur_out()), 32'(mk_out(1, 1, 0, 1, 2'b00, 2'b00, 1, 0, 0)));
`ifdef HAZ_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd1);
    chk("flush_cnt", flush_cnt, 32'd2);
`endif
    #2 rst = 1'b0;
    #1 chk("rst_mid_drain", 32'(cur_out()), 32'(o_init));
`ifdef HAZ_PERF_EN
    chk("stall_cnt_rst", stall_cnt, 32'd0);
    chk("flush_cnt_rst", flush_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(nop);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("reinit%0d", i), 32'(cur_out()), 32'(o_init));
      @(negedge clk);
    end
    #1 chk("rerun", 32'(cur_out()), 32'(o0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
